// File: rtl/fir_out_requant.sv
// fir_out_requant
// Requantises serial-FIR results to OUT_W bits with round-half-up and
// saturation, decimates by DEC, and buffers kept samples in a
// first-word-fall-through FIFO with sticky saturation/overflow flags.

module fir_out_requant #(
   parameter int IN_W  = 29,
   parameter int OUT_W = 12,
   parameter int SHIFT = 17,
   parameter int DEC   = 2,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       valid,
   input  logic signed [IN_W-1:0]     yout,
   output logic signed [OUT_W-1:0]    dout,
   output logic                       dout_valid,
   input  logic                       dout_ready,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       sat_flag,
   output logic                       ovf_flag
);

   localparam int SUM_W  = IN_W + 1;
   localparam int AW     = $clog2(DEPTH);
   localparam int LW     = AW + 1;
   localparam int DCNT_W = (DEC > 1) ? $clog2(DEC) : 1;

   localparam logic signed [SUM_W-1:0] ROUND_C = SUM_W'(1) << (SHIFT - 1);
   localparam logic signed [SUM_W-1:0] MAX_V   = (SUM_W'(1) << (OUT_W - 1)) - SUM_W'(1);
   localparam logic signed [SUM_W-1:0] MIN_V   = SUM_W'(0) - (SUM_W'(1) << (OUT_W - 1));
   localparam logic [DCNT_W-1:0]       DCNT_LAST = DCNT_W'(DEC - 1);
   localparam logic [LW-1:0]           LEVEL_FULL = LW'(DEPTH);

   logic signed [SUM_W-1:0] w_sum;
   logic signed [SUM_W-1:0] w_shifted;
   logic signed [OUT_W-1:0] w_satVal;
   logic                    w_clamp;
   logic                    w_satEvent;

   logic signed [OUT_W-1:0] r_s1Data;
   logic                    r_s1Keep;
   logic [DCNT_W-1:0]       r_dcnt;

   logic signed [OUT_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]           r_wptr;
   logic [AW-1:0]           r_rptr;
   logic [LW-1:0]           r_level;
   logic                    r_satFlag;
   logic                    r_ovfFlag;

   logic                    w_full;
   logic                    w_empty;
   logic                    w_pop;
   logic                    w_wrAccept;
   logic                    w_ovfEvent;

   // The sum is one bit wider than the input so adding the rounding
   // constant can never wrap before the arithmetic shift.
   assign w_sum     = SUM_W'(yout) + ROUND_C;
   assign w_shifted = w_sum >>> SHIFT;

   // Clamp the shifted value into the signed output range and note clamping.
   always_comb begin
      w_satVal = w_shifted[OUT_W-1:0];
      w_clamp  = 1'b0;
      if (w_shifted > MAX_V) begin
         w_satVal = MAX_V[OUT_W-1:0];
         w_clamp  = 1'b1;
      end else if (w_shifted < MIN_V) begin
         w_satVal = MIN_V[OUT_W-1:0];
         w_clamp  = 1'b1;
      end
   end

   assign w_satEvent = valid && w_clamp;

   // Stage 1: register every requantised sample and decide whether the
   // decimator keeps it; the keep bit is a one-cycle write request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1Data <= '0;
         r_s1Keep <= 1'b0;
         r_dcnt   <= '0;
      end else begin
         r_s1Keep <= valid && (r_dcnt == '0);
         if (valid) begin
            r_s1Data <= w_satVal;
            r_dcnt   <= (r_dcnt == DCNT_LAST) ? '0 : r_dcnt + DCNT_W'(1);
         end
      end
   end

   assign w_full     = (r_level == LEVEL_FULL);
   assign w_empty    = (r_level == '0);
   assign w_pop      = !w_empty && dout_ready;
   // A pop frees the head slot on the same edge, so a full FIFO can still
   // take the incoming sample when it is being read.
   assign w_wrAccept = r_s1Keep && (!w_full || w_pop);
   assign w_ovfEvent = r_s1Keep && w_full && !w_pop;

   // Stage 2: storage array write; contents behind the pointers are never
   // observable, so the array itself needs no reset.
   always_ff @(posedge clk) begin
      if (w_wrAccept) begin
         r_mem[r_wptr] <= r_s1Data;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_wrAccept) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         case ({w_wrAccept, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Sticky flags: a new event wins over a coincident clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_satFlag <= 1'b0;
         r_ovfFlag <= 1'b0;
      end else begin
         if (w_satEvent) begin
            r_satFlag <= 1'b1;
         end else if (clr) begin
            r_satFlag <= 1'b0;
         end
         if (w_ovfEvent) begin
            r_ovfFlag <= 1'b1;
         end else if (clr) begin
            r_ovfFlag <= 1'b0;
         end
      end
   end

   // Fall-through head: dout is forced to zero whenever nothing is stored,
   // which also gives the zero value straight out of reset.
   assign dout       = w_empty ? '0 : r_mem[r_rptr];
   assign dout_valid = !w_empty;
   assign level      = r_level;
   assign sat_flag   = r_satFlag;
   assign ovf_flag   = r_ovfFlag;

endmodule

// File: tb/tb_fir_out_requant.sv
// Directed bench for fir_out_requant: one instance with DEC=1 and one with
// DEC=2 share the same stimulus; each scenario checks the relevant instance.

module tb_fir_out_requant;

   logic               clk;
   logic               rst;
   logic               clr;
   logic               valid;
   logic signed [28:0] yout;
   logic               dout_ready;

   logic signed [11:0] dout1;
   logic               doutValid1;
   logic [3:0]         level1;
   logic               satFlag1;
   logic               ovfFlag1;

   logic signed [11:0] dout2;
   logic               doutValid2;
   logic [3:0]         level2;
   logic               satFlag2;
   logic               ovfFlag2;

   int checksTotal;
   int checksPassed;

   typedef struct {
      logic signed [28:0] yin;
      int                 expDout;
      int                 expSat;
   } vec_t;

   vec_t vecs [5];

   fir_out_requant #(.IN_W(29), .OUT_W(12), .SHIFT(17), .DEC(1), .DEPTH(8)) dut1 (
      .clk(clk), .rst(rst), .clr(clr), .valid(valid), .yout(yout),
      .dout(dout1), .dout_valid(doutValid1), .dout_ready(dout_ready),
      .level(level1), .sat_flag(satFlag1), .ovf_flag(ovfFlag1)
   );

   fir_out_requant #(.IN_W(29), .OUT_W(12), .SHIFT(17), .DEC(2), .DEPTH(8)) dut2 (
      .clk(clk), .rst(rst), .clr(clr), .valid(valid), .yout(yout),
      .dout(dout2), .dout_valid(doutValid2), .dout_ready(dout_ready),
      .level(level2), .sat_flag(satFlag2), .ovf_flag(ovfFlag2)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      checksTotal++;
      if (actual == expected) begin
         checksPassed++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // One-cycle valid strobe; returns just after the edge that samples it.
   task automatic applyStimulus(input logic signed [28:0] v);
      valid = 1'b1;
      yout  = v;
      tick();
      valid = 1'b0;
      yout  = '0;
   endtask

   // Strobe followed by the rest of the eight-cycle FIR cadence.
   task automatic sendSample(input logic signed [28:0] v);
      applyStimulus(v);
      idle(7);
   endtask

   task automatic doReset();
      rst        = 1'b1;
      valid      = 1'b0;
      clr        = 1'b0;
      yout       = '0;
      dout_ready = 1'b0;
      idle(2);
      rst = 1'b0;
      tick();
   endtask

   initial begin
      checksTotal  = 0;
      checksPassed = 0;
      rst          = 1'b1;
      clr          = 1'b0;
      valid        = 1'b0;
      yout         = '0;
      dout_ready   = 1'b0;

      vecs[0] = '{yin: 29'sd65536,     expDout: 1,    expSat: 0};
      vecs[1] = '{yin: -29'sd65536,    expDout: 0,    expSat: 0};
      vecs[2] = '{yin: 29'sd65535,     expDout: 0,    expSat: 0};
      vecs[3] = '{yin: -29'sd65537,    expDout: -1,   expSat: 0};
      vecs[4] = '{yin: 29'sd268435455, expDout: 2047, expSat: 1};

      #2;
      checkOutput("reset dout", dout1, 0);
      checkOutput("reset dout_valid", doutValid1, 0);
      checkOutput("reset level", level1, 0);
      checkOutput("reset sat_flag", satFlag1, 0);
      checkOutput("reset ovf_flag", ovfFlag1, 0);
      doReset();

      // Rounding and positive saturation, consumer always ready.
      dout_ready = 1'b1;
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].yin);
         checkOutput($sformatf("vec%0d valid one edge later", i), doutValid1, 0);
         tick();
         checkOutput($sformatf("vec%0d dout_valid", i), doutValid1, 1);
         checkOutput($sformatf("vec%0d dout", i), dout1, vecs[i].expDout);
         checkOutput($sformatf("vec%0d level", i), level1, 1);
         checkOutput($sformatf("vec%0d sat_flag", i), satFlag1, vecs[i].expSat);
         idle(6);
         checkOutput($sformatf("vec%0d drained", i), level1, 0);
      end

      clr = 1'b1;
      tick();
      clr = 1'b0;
      checkOutput("clr sat_flag", satFlag1, 0);
      applyStimulus(-29'sd268435456);
      tick();
      checkOutput("neg full-scale dout", dout1, -2048);
      checkOutput("neg full-scale no sat", satFlag1, 0);
      idle(6);

      // Decimation by two on dut2.
      doReset();
      for (int k = 0; k < 6; k++) sendSample(29'(k * 131072));
      checkOutput("dec level", level2, 3);
      dout_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         checkOutput($sformatf("dec dout%0d", k), dout2, 2 * k);
         tick();
      end
      checkOutput("dec empty", doutValid2, 0);
      dout_ready = 1'b0;

      // Overflow: ten kept samples into an eight-deep FIFO.
      doReset();
      for (int k = 1; k <= 10; k++) begin
         sendSample(29'(k * 131072));
         if (k == 8) checkOutput("ovf not yet at 8", ovfFlag1, 0);
      end
      checkOutput("ovf level", level1, 8);
      checkOutput("ovf flag", ovfFlag1, 1);
      dout_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         checkOutput($sformatf("ovf drain%0d", k), dout1, k);
         tick();
      end
      checkOutput("ovf drained level", level1, 0);
      checkOutput("ovf drained valid", doutValid1, 0);
      checkOutput("ovf flag sticky", ovfFlag1, 1);
      dout_ready = 1'b0;

      // Full FIFO with write and pop on the same edge.
      doReset();
      for (int k = 1; k <= 8; k++) sendSample(29'(k * 131072));
      checkOutput("full level", level1, 8);
      applyStimulus(29'(9 * 131072));
      dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0;
      checkOutput("rw full level", level1, 8);
      checkOutput("rw full no ovf", ovfFlag1, 0);
      checkOutput("rw full head", dout1, 2);
      dout_ready = 1'b1;
      for (int k = 2; k <= 9; k++) begin
         checkOutput($sformatf("rw drain%0d", k), dout1, k);
         tick();
      end
      checkOutput("rw drained", doutValid1, 0);
      dout_ready = 1'b0;

      // Asynchronous reset with stored samples and one in stage 1.
      doReset();
      sendSample(29'sd268435455);
      for (int k = 1; k <= 4; k++) sendSample(29'(k * 131072));
      checkOutput("pre-rst level", level1, 5);
      checkOutput("pre-rst sat", satFlag1, 1);
      applyStimulus(29'(7 * 131072));
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async rst dout", dout1, 0);
      checkOutput("async rst valid", doutValid1, 0);
      checkOutput("async rst level", level1, 0);
      checkOutput("async rst sat", satFlag1, 0);
      checkOutput("async rst ovf", ovfFlag1, 0);
      #2;
      rst = 1'b0;
      idle(3);
      checkOutput("in-flight discarded", doutValid1, 0);
      applyStimulus(29'(3 * 131072));
      checkOutput("post-rst latency low", doutValid1, 0);
      checkOutput("post-rst dec2 latency low", doutValid2, 0);
      tick();
      checkOutput("post-rst valid", doutValid1, 1);
      checkOutput("post-rst dout", dout1, 3);
      checkOutput("post-rst dec2 kept", doutValid2, 1);
      checkOutput("post-rst dec2 dout", dout2, 3);

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule

// File: doc/fir_out_requant.md
FIR_OUT_REQUANT -- requirements
Module: fir_out_requant

Parameters
REQ-001 SHALL provide parameters, one per line:
- IN_W, 29, signed input width.
- OUT_W, 12, signed output width.
- SHIFT, 17, right-shift applied during requantisation (SHIFT >= 1).
- DEC, 2, decimation factor (DEC >= 1).
- DEPTH, 8, output FIFO depth (power of two).

Interface
REQ-002 SHALL have one clock; reset is asynchronous and active-high. Ports, one per line:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- clr  in  1  synchronous clear of sticky flags only.
- valid  in  1  one-cycle strobe marking yout as a new filter result.
- yout  in  IN_W  signed serial-FIR output sample.
- dout  out  OUT_W  signed requantised sample at FIFO head.
- dout_valid  out  1  FIFO non-empty, so dout is valid.
- dout_ready  in  1  consumer accepts dout when high together with dout_valid.
- level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- sat_flag  out  1  sticky flag: a saturation has occurred.
- ovf_flag  out  1  sticky flag: a kept sample was dropped because the FIFO was full.

Function
REQ-003 SHALL treat valid as a single-cycle strobe; back-to-back valid cycles SHALL each be processed as separate samples.
REQ-004 Stage 1 arithmetic, registered on each rising edge where valid=1:
- Form s = yout + 2^(SHIFT-1) in IN_W+1 bits (no wrap).
- Arithmetically shift s right by SHIFT (round half up toward +inf).
REQ-005 SHALL saturate the stage-1 result to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and set sat_flag whenever clamping occurs.
REQ-006 SHALL keep a decimation counter dcnt in 0..DEC-1:
- dcnt advances on each valid and wraps from DEC-1 to 0.
- Only samples arriving when dcnt==0 are kept.
- DEC=1 keeps every sample.
REQ-007 SHALL write each kept sample into the FIFO on the edge after stage 1 registers it (stage 2).
REQ-008 SHALL implement the FIFO as first-word-fall-through:
- dout reflects the head entry whenever dout_valid=1.
- Minimum latency is 2 cycles from the valid edge to dout_valid high, with the FIFO empty.
REQ-009 SHALL pop the head entry on any edge where dout_valid and dout_ready are both 1.
REQ-010 When dout_valid=0, dout_ready SHALL be ignored; level SHALL not underflow.
REQ-011 On write while full with no pop in the same cycle:
- The sample is discarded and ovf_flag is set.
- FIFO contents and level are unchanged.
REQ-012 On simultaneous write and pop while full, the write SHALL be accepted and level SHALL stay DEPTH.
REQ-013 On simultaneous write and pop at other levels, level SHALL be unchanged and data order SHALL be preserved.
REQ-014 Read and write pointers SHALL wrap modulo DEPTH; full SHALL be level==DEPTH and empty SHALL be level==0.
REQ-015 sat_flag and ovf_flag SHALL remain set until rst or clr.
REQ-016 If clr coincides with a new flag event, the set SHALL win.
REQ-017 clr SHALL not affect dcnt, the FIFO, or the datapath.

Reset
REQ-018 On rst assertion, independent of clk, SHALL immediately force:
- dout=0, dout_valid=0, level=0.
- sat_flag=0, ovf_flag=0.
- dcnt=0, FIFO pointers=0, stage-1 and stage-2 registers cleared.
REQ-019 Reset mid-operation SHALL discard all in-flight and stored samples.
REQ-020 The first valid after rst deasserts SHALL be treated as a kept sample (dcnt==0).
REQ-021 rst deassertion SHALL take effect at the next rising clk edge.

Verification
REQ-022 The bench SHALL drive valid one cycle in eight, matching the serial-FIR cadence, and SHALL cover these directed scenarios (defaults, DEC=1 unless stated):
- Rounding: yout=65536, -65536, 65535, -65537 -> dout=1, 0, 0, -1; sat_flag=0; dout_valid 2 cycles after each valid.
- Saturation: yout=2^28-1 -> dout=2047, sat_flag=1. yout=-2^28 -> dout=-2048, no new saturation. clr -> sat_flag=0 next cycle.
- Decimation, DEC=2: inputs k*131072 for k=0..5 -> FIFO receives 0, 2, 4 in order.
- Overflow: dout_ready=0, 10 kept samples -> level=8, ovf_flag=1, first 8 values retained. Then dout_ready=1 -> drains in order, level reaches 0, dout_valid=0.
- Full plus simultaneous read/write: level=8, valid and a pop on the same edge -> level stays 8, no ovf, new sample appears at tail.
- Reset mid-stream: assert rst asynchronously with level=5 and a sample in stage 1 -> all outputs 0 immediately; after release, the next valid produces the first output 2 cycles later.
